// File: rtl/ram_rmw_bridge.sv
// Valid/ready front end for a combinational-read, single-write-enable RAM.
// Partial-word stores become read-modify-write; responses can be delayed.
module ram_rmw_bridge #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_DELAY = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic [ADDR_WIDTH-1:0]   ram_a,
  output logic [DATA_WIDTH-1:0]   ram_d,
  output logic                    ram_we,
  input  logic [DATA_WIDTH-1:0]   ram_spo
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, RD, WR, DLY, RSP} state_t;

  localparam state_t AFTER_DATA = (RESP_DELAY == 0) ? RSP : DLY;
  localparam logic [7:0] DLY_LOAD = 8'((RESP_DELAY == 0) ? 0 : RESP_DELAY - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [STRB_W-1:0]       strb_q, strb_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   merge_q, merge_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   merged;

  // Only the word-address bits matter; the rest alias onto the same word.
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

  always_comb begin
    merged = '0;
    for (int i = 0; i < STRB_W; i++) begin
      merged[8*i +: 8] = strb_q[i] ? wdata_q[8*i +: 8] : ram_spo[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[ADDR_WIDTH+1:2];
          strb_d  = req_wstrb;
          wdata_d = req_wdata;
          if (&req_wstrb) begin
            merge_d = req_wdata;
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (strb_q == '0) begin
          rdata_d = ram_spo;
          cnt_d   = DLY_LOAD;
          state_d = AFTER_DATA;
        end else begin
          merge_d = merged;
          state_d = WR;
        end
      end
      WR: begin
        rdata_d = merge_q;
        cnt_d   = DLY_LOAD;
        state_d = AFTER_DATA;
      end
      DLY: begin
        if (cnt_q == 8'd0) begin
          state_d = RSP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RSP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset gates the handshake and the write strobe immediately so an
  // in-flight WR never reaches the RAM.
  assign req_ready  = (state_q == IDLE) && !reset;
  assign ram_we     = (state_q == WR) && !reset;
  assign resp_valid = (state_q == RSP);
  assign resp_rdata = rdata_q;
  assign ram_a      = addr_q;
  assign ram_d      = merge_q;

endmodule

// File: tb/tb_ram_rmw_bridge.sv
// Bench for ram_rmw_bridge: two instances (no delay and RESP_DELAY=3), each
// with its own RAM, checked every cycle against a transaction-level model.
module tb_ram_rmw_bridge;

  logic clk = 1'b0;
  logic reset;

  logic        reqValid  [2];
  logic        reqReady  [2];
  logic [31:0] reqAddr   [2];
  logic [3:0]  reqWstrb  [2];
  logic [31:0] reqWdata  [2];
  logic        respValid [2];
  logic        respReady [2];
  logic [31:0] respRdata [2];
  logic [14:0] ramA      [2];
  logic [31:0] ramD      [2];
  logic        ramWe     [2];
  logic [31:0] ramSpo    [2];

  logic [31:0] ram0 [0:32767];
  logic [31:0] ram1 [0:32767];

  int checks = 0;
  int failures = 0;
  int weCount [2];

  always #5 clk = ~clk;

  ram_rmw_bridge #(.ADDR_WIDTH(15), .DATA_WIDTH(32), .RESP_DELAY(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_addr(reqAddr[0]),
    .req_wstrb(reqWstrb[0]), .req_wdata(reqWdata[0]),
    .resp_valid(respValid[0]), .resp_ready(respReady[0]), .resp_rdata(respRdata[0]),
    .ram_a(ramA[0]), .ram_d(ramD[0]), .ram_we(ramWe[0]), .ram_spo(ramSpo[0])
  );

  ram_rmw_bridge #(.ADDR_WIDTH(15), .DATA_WIDTH(32), .RESP_DELAY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_addr(reqAddr[1]),
    .req_wstrb(reqWstrb[1]), .req_wdata(reqWdata[1]),
    .resp_valid(respValid[1]), .resp_ready(respReady[1]), .resp_rdata(respRdata[1]),
    .ram_a(ramA[1]), .ram_d(ramD[1]), .ram_we(ramWe[1]), .ram_spo(ramSpo[1])
  );

  // Simulation RAMs: combinational read, write on posedge.
  assign ramSpo[0] = ram0[ramA[0]];
  assign ramSpo[1] = ram1[ramA[1]];

  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram0[i] = 32'h0;
      ram1[i] = 32'h0;
    end
    ram0[16'h10] = 32'hDEADBEEF;
    ram1[16'h10] = 32'hDEADBEEF;
    ram1[16'h12] = 32'h55667788;
    forever begin
      @(posedge clk);
      if (ramWe[0]) ram0[ramA[0]] <= ramD[0];
      if (ramWe[1]) ram1[ramA[1]] <= ramD[1];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding request per instance, its
  // response age, expected write cycle and data, and a reference memory.
  initial begin : model
    logic [31:0] refMem [2][32768];
    int          pending [2];
    int          age [2];
    int          lat [2];
    int          wrAge [2];
    logic [31:0] expData [2];
    logic [14:0] expWord [2];
    logic [31:0] old;
    logic        expValid, expReady, expWe;
    int          dly;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 32768; i++) refMem[s][i] = 32'h0;
      pending[s] = 0; age[s] = 0; lat[s] = 0; wrAge[s] = -1;
      expData[s] = 32'h0; expWord[s] = 15'h0; weCount[s] = 0;
    end
    refMem[0][16'h10] = 32'hDEADBEEF;
    refMem[1][16'h10] = 32'hDEADBEEF;
    refMem[1][16'h12] = 32'h55667788;
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        dly = (s == 0) ? 0 : 3;
        expValid = (pending[s] != 0) && (age[s] >= lat[s]);
        expReady = !reset && (pending[s] == 0);
        expWe    = !reset && (pending[s] != 0) && (age[s] == wrAge[s]);
        checkOutput($sformatf("dut%0d req_ready", s), {31'h0, reqReady[s]}, {31'h0, expReady});
        checkOutput($sformatf("dut%0d resp_valid", s), {31'h0, respValid[s]}, {31'h0, expValid});
        checkOutput($sformatf("dut%0d ram_we", s), {31'h0, ramWe[s]}, {31'h0, expWe});
        if (expValid) checkOutput($sformatf("dut%0d resp_rdata", s), respRdata[s], expData[s]);
        if (expWe) begin
          checkOutput($sformatf("dut%0d ram_a", s), {17'h0, ramA[s]}, {17'h0, expWord[s]});
          checkOutput($sformatf("dut%0d ram_d", s), ramD[s], expData[s]);
          refMem[s][expWord[s]] = expData[s];
        end
        if (ramWe[s]) weCount[s]++;
        if (reset) begin
          pending[s] = 0;
        end else if (pending[s] != 0) begin
          if (expValid && respReady[s]) pending[s] = 0;
          else age[s]++;
        end else if (reqValid[s]) begin
          expWord[s] = reqAddr[s][16:2];
          old = refMem[s][expWord[s]];
          if (reqWstrb[s] == 4'b0000) begin
            expData[s] = old;
            wrAge[s]   = -1;
            lat[s]     = 2 + dly;
          end else begin
            for (int b = 0; b < 4; b++)
              expData[s][8*b +: 8] = reqWstrb[s][b] ? reqWdata[s][8*b +: 8] : old[8*b +: 8];
            wrAge[s] = (reqWstrb[s] == 4'b1111) ? 1 : 2;
            lat[s]   = ((reqWstrb[s] == 4'b1111) ? 2 : 3) + dly;
          end
          pending[s] = 1;
          age[s]     = 1;
        end
      end
    end
  end

  // One full transaction with hand-computed data, latency and write count.
  task automatic applyStimulus(input int s, input logic [31:0] addr, input logic [3:0] strb,
                               input logic [31:0] wd, input int stall, input logic [31:0] expRdata,
                               input int expLat, input int expWe, input string name);
    int cyc;
    int we0;
    we0 = weCount[s];
    reqAddr[s]  = addr;
    reqWstrb[s] = strb;
    reqWdata[s] = wd;
    reqValid[s] = 1'b1;
    cyc = 0;
    while (!reqReady[s] && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    if (!reqReady[s]) begin
      checks++; failures++;
      $display("[TB] FAIL %s accept timeout actual=not-ready required=ready", name);
      reqValid[s] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    reqValid[s] = 1'b0;
    cyc = 1;
    while (!respValid[s] && cyc < 300) begin
      @(posedge clk); #1; cyc++;
    end
    checkOutput({name, " latency"}, cyc, expLat);
    checkOutput({name, " rdata"}, respRdata[s], expRdata);
    repeat (stall) begin
      @(posedge clk); #1;
    end
    checkOutput({name, " rdata after stall"}, respRdata[s], expRdata);
    respReady[s] = 1'b1;
    @(posedge clk); #1;
    respReady[s] = 1'b0;
    checkOutput({name, " we pulses"}, weCount[s] - we0, expWe);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      reqValid[s] = 1'b0; reqAddr[s] = 32'h0; reqWstrb[s] = 4'h0;
      reqWdata[s] = 32'h0; respReady[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset req_ready", {31'h0, reqReady[0]}, 32'h0);
    checkOutput("reset resp_valid", {31'h0, respValid[0]}, 32'h0);
    checkOutput("reset resp_rdata", respRdata[0], 32'h0);
    checkOutput("reset ram_a", {17'h0, ramA[0]}, 32'h0);
    checkOutput("reset ram_d", ramD[0], 32'h0);
    checkOutput("reset ram_we", {31'h0, ramWe[0]}, 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("ready after reset dut0", {31'h0, reqReady[0]}, 32'h1);
    checkOutput("ready after reset dut3", {31'h0, reqReady[1]}, 32'h1);

    applyStimulus(0, 32'h0000_0040, 4'b0000, 32'h0, 0, 32'hDEADBEEF, 2, 0, "read 0x40");
    applyStimulus(0, 32'h0002_0040, 4'b0000, 32'h0, 0, 32'hDEADBEEF, 2, 0, "alias read");
    checkOutput("alias ram_a", {17'h0, ramA[0]}, 32'h10);
    applyStimulus(0, 32'h0000_0040, 4'b0101, 32'h11223344, 0, 32'hDE22BE44, 3, 1, "partial store");
    applyStimulus(0, 32'h0000_0040, 4'b0000, 32'h0, 0, 32'hDE22BE44, 2, 0, "read after partial");
    applyStimulus(0, 32'h0000_0044, 4'b1111, 32'h12345678, 1, 32'h12345678, 2, 1, "full store");
    checkOutput("full store ram_a", {17'h0, ramA[0]}, 32'h11);
    checkOutput("full store ram_d", ramD[0], 32'h12345678);
    applyStimulus(0, 32'h0000_0044, 4'b0000, 32'h0, 0, 32'h12345678, 2, 0, "read after full");

    applyStimulus(1, 32'h0000_0040, 4'b0000, 32'h0, 5, 32'hDEADBEEF, 5, 0, "delayed read stall");
    applyStimulus(1, 32'h0000_0048, 4'b0011, 32'h0000CAFE, 0, 32'h5566CAFE, 6, 1, "delayed partial");
    applyStimulus(1, 32'h0000_0048, 4'b0000, 32'h0, 2, 32'h5566CAFE, 5, 0, "delayed readback");

    // Reset during the WR cycle of a partial store must suppress the write.
    reqAddr[0] = 32'h0000_0044; reqWstrb[0] = 4'b1000; reqWdata[0] = 32'hAA000000;
    reqValid[0] = 1'b1;
    @(posedge clk); #1;
    reqValid[0] = 1'b0;
    @(posedge clk); #1;
    checkOutput("we in WR before reset", {31'h0, ramWe[0]}, 32'h1);
    reset = 1'b1;
    #1;
    checkOutput("we forced low by reset", {31'h0, ramWe[0]}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("ready after mid-WR reset", {31'h0, reqReady[0]}, 32'h1);
    checkOutput("no resp after mid-WR reset", {31'h0, respValid[0]}, 32'h0);
    applyStimulus(0, 32'h0000_0044, 4'b0000, 32'h0, 0, 32'h12345678, 2, 0, "word kept after reset");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
